// File: rtl/led_array_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : led_array_decoder
//  Function : Rebuilds the N x N frame from a multiplexed rows/cols LED scan
//             bus; publishes completed frames through a valid/ready handshake.
//             Optional macro: LED_DECODER_CONSISTENCY_CHECK_EN
//  Revision : 1.0 - initial release
// ============================================================================
module led_array_decoder #(
  parameter int N             = 8,
  parameter int SETTLE        = 2,
  parameter int BLANK_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   rows,
  input  logic [N-1:0]   cols,
  output logic [N*N-1:0] cells,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic           overrun,
  output logic           onehot_err,
  output logic           mismatch
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int BW = $clog2(BLANK_TIMEOUT + 1);
  localparam logic [SW-1:0] c_settle   = SW'(SETTLE);
  localparam logic [BW-1:0] c_blank_to = BW'(BLANK_TIMEOUT);
  localparam logic [N-1:0]  c_one      = N'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLING = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_rows, r_cols, r_prev_rows, r_prev_cols;
  logic [SW-1:0]  r_cnt, w_cnt_nxt;
  logic [BW-1:0]  r_blank, w_blank_nxt;
  logic [N*N-1:0] r_partial, r_cells;
  logic [N-1:0]   r_seen;
  logic           r_frame_valid, r_overrun, r_onehot_err;

  logic           w_is_blank, w_is_bad, w_same;
  logic           w_capture, w_timeout, w_complete, w_restart;
  logic [N*N-1:0] w_part_cap, w_part_new, w_restart_part;
  logic [N-1:0]   w_seen_new;

  assign w_is_blank = (r_cols == '0);
  assign w_is_bad   = |(r_cols & (r_cols - c_one));
  assign w_same     = (r_rows == r_prev_rows) && (r_cols == r_prev_cols);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_blank_nxt = r_blank;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    if (w_is_blank) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      if (r_blank != c_blank_to) w_blank_nxt = r_blank + BW'(1);
      w_timeout   = (w_blank_nxt == c_blank_to);
    end else if (w_is_bad) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_blank_nxt = '0;
    end else begin
      w_blank_nxt = '0;
      // A held column stays held until the sampled pair changes.
      if (!(w_same && r_state == S_HELD)) begin
        if (w_same && r_state == S_SETTLING) begin
          if (r_cnt != c_settle) w_cnt_nxt = r_cnt + SW'(1);
        end else begin
          w_cnt_nxt = SW'(1);
        end
        if (w_cnt_nxt == c_settle) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HELD;
        end else begin
          w_state_nxt = S_SETTLING;
        end
      end
    end
  end

  always_comb begin
    w_part_cap = r_partial;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (r_cols[c]) w_part_cap[N*r+c] = r_rows[r];
      end
    end
  end

`ifdef LED_DECODER_CONSISTENCY_CHECK_EN
  logic w_conflict;
  logic r_mismatch;

  always_comb begin
    w_conflict     = 1'b0;
    w_restart_part = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (r_cols[c]) begin
          if (r_seen[c] && (r_partial[N*r+c] != r_rows[r])) w_conflict = 1'b1;
          w_restart_part[N*r+c] = r_rows[r];
        end
      end
    end
  end

  assign w_restart = w_capture & w_conflict;

  always_ff @(posedge clk) begin
    if (!rst_n)         r_mismatch <= 1'b0;
    else if (w_restart) r_mismatch <= 1'b1;
  end

  assign mismatch = r_mismatch;
`else
  assign w_restart      = 1'b0;
  assign w_restart_part = '0;
  assign mismatch       = 1'b0;
`endif

  // A conflicting recapture restarts the frame with only that column kept.
  assign w_part_new = w_restart ? w_restart_part : w_part_cap;
  assign w_seen_new = w_restart ? r_cols : (r_seen | r_cols);
  assign w_complete = w_capture & (&w_seen_new);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rows        <= '0;
      r_cols        <= '0;
      r_prev_rows   <= '0;
      r_prev_cols   <= '0;
      r_cnt         <= '0;
      r_blank       <= '0;
      r_partial     <= '0;
      r_seen        <= '0;
      r_cells       <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
      r_onehot_err  <= 1'b0;
    end else begin
      r_rows      <= rows;
      r_cols      <= cols;
      r_prev_rows <= r_rows;
      r_prev_cols <= r_cols;
      r_cnt       <= w_cnt_nxt;
      r_blank     <= w_blank_nxt;
      if (w_is_bad) r_onehot_err <= 1'b1;
      if (w_timeout) begin
        r_partial <= '0;
        r_seen    <= '0;
      end else if (w_complete) begin
        r_cells       <= w_part_new;
        r_partial     <= '0;
        r_seen        <= '0;
        r_frame_valid <= 1'b1;
        if (r_frame_valid && !frame_ready) r_overrun <= 1'b1;
      end else if (w_capture) begin
        r_partial <= w_part_new;
        r_seen    <= w_seen_new;
      end
      if (!w_complete && r_frame_valid && frame_ready) r_frame_valid <= 1'b0;
    end
  end

  assign cells       = r_cells;
  assign frame_valid = r_frame_valid;
  assign overrun     = r_overrun;
  assign onehot_err  = r_onehot_err;

endmodule
`default_nettype wire

// File: tb/tb_led_array_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_array_decoder
//  Function : Randomised and directed scan-bus stimulus for led_array_decoder,
//             compared against a column-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_array_decoder;

  localparam int N  = 8;
  localparam int ST = 2;
  localparam int BT = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   rows = '0;
  logic [N-1:0]   cols = '0;
  logic           frame_ready = 1'b0;
  logic [N*N-1:0] cells;
  logic           frame_valid, overrun, onehot_err, mismatch;

  int checks = 0;
  int failures = 0;

  led_array_decoder #(.N(N), .SETTLE(ST), .BLANK_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n), .rows(rows), .cols(cols), .cells(cells),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .overrun(overrun),
    .onehot_err(onehot_err), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // Reference model: frame kept as an array of column vectors.
  logic           m_live = 1'b0;
  logic [N-1:0]   m_srows = '0, m_scols = '0, m_prows = '0, m_pcols = '0;
  logic [N-1:0]   m_sr, m_sc;
  logic [N-1:0]   m_col [N];
  logic [N-1:0]   m_seen = '0;
  logic [N*N-1:0] m_cells = '0;
  logic           m_valid = 1'b0, m_overrun = 1'b0, m_err = 1'b0, m_mm = 1'b0;
  logic           m_consume, m_done;
  int             m_run = 0, m_blank_run = 0, m_ci;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_live = 1'b1;
      m_srows = '0; m_scols = '0; m_prows = '0; m_pcols = '0;
      m_run = 0; m_blank_run = 0; m_seen = '0;
      for (int c = 0; c < N; c++) m_col[c] = '0;
      m_cells = '0; m_valid = 1'b0; m_overrun = 1'b0; m_err = 1'b0; m_mm = 1'b0;
    end else begin
      m_sr = m_srows; m_sc = m_scols;
      m_srows = rows; m_scols = cols;
      m_consume = m_valid && frame_ready;
      m_done = 1'b0;
      if ($countones(m_sc) == 0) begin
        m_run = 0;
        if (m_blank_run < BT) m_blank_run++;
        if (m_blank_run >= BT) begin
          m_seen = '0;
          for (int c = 0; c < N; c++) m_col[c] = '0;
        end
      end else if ($countones(m_sc) > 1) begin
        m_err = 1'b1; m_run = 0; m_blank_run = 0;
      end else begin
        m_blank_run = 0;
        if (m_run > 0 && m_sr == m_prows && m_sc == m_pcols) m_run++;
        else m_run = 1;
        if (m_run == ST) begin
          m_ci = $clog2(m_sc);
`ifdef LED_DECODER_CONSISTENCY_CHECK_EN
          if (m_seen[m_ci] && m_col[m_ci] != m_sr) begin
            m_mm = 1'b1;
            m_seen = '0;
            for (int c = 0; c < N; c++) m_col[c] = '0;
          end
`endif
          m_col[m_ci] = m_sr;
          m_seen[m_ci] = 1'b1;
          if (&m_seen) begin
            for (int r = 0; r < N; r++)
              for (int c = 0; c < N; c++) m_cells[N*r+c] = m_col[c][r];
            if (m_valid && !frame_ready) m_overrun = 1'b1;
            m_valid = 1'b1; m_done = 1'b1; m_seen = '0;
            for (int c = 0; c < N; c++) m_col[c] = '0;
          end
        end
      end
      m_prows = m_sr; m_pcols = m_sc;
      if (m_consume && !m_done) m_valid = 1'b0;
    end
  end

  task automatic check_vec(input string name, input logic [N*N-1:0] act, input logic [N*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (valid,overrun,onehot_err,mismatch)", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      check_vec("model_cells", cells, m_cells);
      check_flags("model_flags", {frame_valid, overrun, onehot_err, mismatch},
                  {m_valid, m_overrun, m_err, m_mm});
    end
  end

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] c, input logic rdy);
    @(negedge clk);
    rows = r; cols = c; frame_ready = rdy;
  endtask

  task automatic dwell(input logic [N-1:0] r, input int col, input int n, input logic rdy);
    logic [N-1:0] cv;
    cv = '0; cv[col] = 1'b1;
    repeat (n) step(r, cv, rdy);
  endtask

  task automatic blank(input int n, input logic rdy);
    repeat (n) step('0, '0, rdy);
  endtask

  task automatic scan_frame(input logic [N-1:0] r, input int n, input logic rdy);
    for (int c = 0; c < N; c++) dwell(r, c, n, rdy);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; rows = '0; cols = '0; frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d, col;
    logic [N-1:0] rv;
    logic rdy;

    // Reset and idle
    do_reset();
    blank(10, 1'b0);
    check_vec("reset_cells", cells, '0);
    check_flags("reset_flags", {frame_valid, overrun, onehot_err, mismatch}, 4'b0000);

    // A5 scan: completion lands exactly on column 7's capture edge
    for (int c = 0; c < N-1; c++) dwell(8'hA5, c, 4, 1'b0);
    dwell(8'hA5, N-1, 2, 1'b0);
    @(posedge clk); #1;
    check_bit("a5_valid_before_capture", frame_valid, 1'b0);
    @(posedge clk); #1;
    check_bit("a5_valid_at_capture", frame_valid, 1'b1);
    check_vec("a5_cells", cells, 64'hFF00FF0000FF00FF);
    check_bit("a5_overrun", overrun, 1'b0);

    // Two unconsumed frames cause overrun; cells hold the second one
    step('0, '0, 1'b1);
    blank(2, 1'b0);
    scan_frame(8'h3C, 4, 1'b0);
    scan_frame(8'hC3, 4, 1'b0);
    blank(2, 1'b0);
    check_bit("ovr_set", overrun, 1'b1);
    check_vec("ovr_cells", cells, 64'hFFFF00000000FFFF);

    // Ready on the second completion edge: no overrun
    do_reset();
    scan_frame(8'h3C, 4, 1'b0);
    for (int c = 0; c < N-1; c++) dwell(8'h81, c, 4, 1'b0);
    dwell(8'h81, N-1, 2, 1'b0);
    dwell(8'h81, N-1, 1, 1'b1);
    dwell(8'h81, N-1, 1, 1'b0);
    blank(2, 1'b0);
    check_bit("ready_pulse_overrun", overrun, 1'b0);
    check_bit("ready_pulse_valid", frame_valid, 1'b1);
    check_vec("ready_pulse_cells", cells, 64'hFF000000000000FF);

    // One-cycle glitch on column 3 is not captured
    do_reset();
    dwell(8'h5A, 0, 4, 1'b0);
    dwell(8'h5A, 1, 4, 1'b0);
    dwell(8'h5A, 2, 4, 1'b0);
    dwell(8'h5A, 3, 1, 1'b0);
    dwell(8'h5A, 2, 4, 1'b0);
    for (int c = 4; c < N; c++) dwell(8'h5A, c, 4, 1'b0);
    blank(3, 1'b0);
    check_bit("glitch_no_frame", frame_valid, 1'b0);
    dwell(8'h5A, 3, 2, 1'b0);
    blank(3, 1'b0);
    check_bit("glitch_then_dwell_frame", frame_valid, 1'b1);

    // Blank timeout discards a partial frame
    do_reset();
    for (int c = 0; c < 4; c++) dwell(8'h0F, c, 4, 1'b0);
    blank(BT, 1'b0);
    for (int c = 4; c < N; c++) dwell(8'h0F, c, 4, 1'b0);
    blank(2, 1'b0);
    check_bit("timeout_no_frame", frame_valid, 1'b0);
    scan_frame(8'h0F, 4, 1'b0);
    blank(2, 1'b0);
    check_bit("rescan_frame", frame_valid, 1'b1);
    step(8'h00, 8'h11, 1'b0);
    blank(2, 1'b0);
    check_bit("bad_sets_err", onehot_err, 1'b1);
    blank(5, 1'b0);
    check_bit("err_sticky", onehot_err, 1'b1);
    do_reset();
    blank(1, 1'b0);
    check_bit("err_cleared_by_reset", onehot_err, 1'b0);

`ifdef LED_DECODER_CONSISTENCY_CHECK_EN
    dwell(8'h01, 2, 3, 1'b0);
    dwell(8'h00, 0, 3, 1'b0);
    dwell(8'h02, 2, 3, 1'b0);
    blank(2, 1'b0);
    check_bit("mismatch_set", mismatch, 1'b1);
    dwell(8'h00, 0, 3, 1'b0);
    dwell(8'h00, 1, 3, 1'b0);
    for (int c = 3; c < N-1; c++) dwell(8'h00, c, 3, 1'b0);
    blank(2, 1'b0);
    check_bit("mismatch_frame_pending", frame_valid, 1'b0);
    dwell(8'h00, N-1, 3, 1'b0);
    blank(2, 1'b0);
    check_bit("mismatch_frame_done", frame_valid, 1'b1);
    do_reset();
`endif

    // Randomised scan traffic
    for (int it = 0; it < 600; it++) begin
      if (it == 300) do_reset();
      k = $urandom_range(0, 19);
      rdy = ($urandom_range(0, 3) == 0);
      if (k < 14) begin
        col = $urandom_range(0, N-1);
        rv  = N'($urandom);
        if ($urandom_range(0, 3) == 0) rv = 8'h3C;
        d   = $urandom_range(1, 5);
        dwell(rv, col, d, rdy);
      end else if (k < 17) begin
        blank($urandom_range(1, 5), rdy);
      end else if (k == 17) begin
        blank($urandom_range(BT - 4, BT + 4), rdy);
      end else if (k == 18 && $urandom_range(0, 5) == 0) begin
        step(N'($urandom), 8'h03 << $urandom_range(0, 6), rdy);
      end else begin
        step('0, '0, 1'b1);
      end
    end
    blank(4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
